// File: rtl/ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types for the RAM port arbiter and its round-robin picker.
//   arb_id_t     : requester index, wide enough for the largest arbiter (8 req)
//   rsp_stage_t  : one response pipe stage {valid, id, we}
//   arb_state_e  : burst lock state
//   STRB_W       : byte lanes of the default 32-bit / 8-bit-lane configuration
// -----------------------------------------------------------------------------
package ram_arb_pkg;

    // Ids are sized for the widest supported arbiter so the response struct
    // can be shared by every instance regardless of its N_REQ.
    localparam int N_REQ_MAX = 8;
    localparam int ID_W      = $clog2(N_REQ_MAX);
    localparam int STRB_W    = 32 / 8;

    typedef logic [ID_W-1:0] arb_id_t;

    typedef struct packed {
        logic    valid;
        arb_id_t id;
        logic    we;
    } rsp_stage_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage : ram_arb_pkg

// File: rtl/ram_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational circular priority search. Starting at ptr_i and wrapping past
// the top index, the first set bit of req_i wins.
//   req_i  : request vector
//   ptr_i  : highest-priority index for this search
//   gnt_o  : one-hot grant (zero when no request)
//   id_o   : index of the granted request
//   any_o  : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] id_o,
    output logic           any_o
);

    always_comb begin
        logic [IDW-1:0] idx;
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDW'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                id_o       = idx;
                any_o      = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
// Shares one RAM port between N_REQ simple requesters with round-robin
// arbitration, burst locking (forced release after MAX_BURST beats) and an
// in-order response pipe matched to the RAM read latency RD_LAT.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/ready_o          per-requester beat handshake
//   req_addr_i/wdata_i/strb_i    packed per-requester beat payload
//   req_we_i, req_last_i         write beat, last beat of burst
//   rsp_valid_o (one-hot), rsp_we_o, rsp_rdata_o   response, no backpressure
//   ram_addr_o/wdata_o/byte_en_o, ram_rdata_i      RAM port
//   burst_ovf_o                  pulse after a forced lock release
// -----------------------------------------------------------------------------
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LAT     = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [N_REQ-1:0]                           req_valid_i,
    output logic [N_REQ-1:0]                           req_ready_o,
    input  logic [N_REQ*ADDR_WIDTH-1:0]                req_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]                req_wdata_i,
    input  logic [N_REQ*(DATA_WIDTH/BYTE_WIDTH)-1:0]   req_strb_i,
    input  logic [N_REQ-1:0]                           req_we_i,
    input  logic [N_REQ-1:0]                           req_last_i,
    output logic [N_REQ-1:0]                           rsp_valid_o,
    output logic                                       rsp_we_o,
    output logic [DATA_WIDTH-1:0]                      rsp_rdata_o,
    output logic [ADDR_WIDTH-1:0]                      ram_addr_o,
    output logic [DATA_WIDTH-1:0]                      ram_wdata_o,
    output logic [DATA_WIDTH/BYTE_WIDTH-1:0]           ram_byte_en_o,
    input  logic [DATA_WIDTH-1:0]                      ram_rdata_i,
    output logic                                       burst_ovf_o
);

    localparam int STRB_N = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDW    = $clog2(N_REQ);
    localparam int CNT_W  = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] id);
        if (int'(id) == N_REQ - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    arb_state_e        state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              ovf_q, ovf_d;
    rsp_stage_t        pipe_q [RD_LAT];
    rsp_stage_t        pipe_d [RD_LAT];
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IDW-1:0]    pick_id;
    logic              pick_any;

    logic [N_REQ-1:0]  gnt_vec;
    logic [IDW-1:0]    gnt_id;
    logic              accept;
    logic              acc_we;
    logic              acc_last;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [STRB_N-1:0]     acc_strb;
    rsp_stage_t        rsp_last;

    rr_pick #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_rr_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .id_o  (pick_id),
        .any_o (pick_any)
    );

    // While locked only the owner may be granted; if it drops valid the port
    // simply idles rather than letting another requester in mid-burst.
    always_comb begin
        gnt_vec = '0;
        gnt_id  = pick_id;
        accept  = 1'b0;
        if (state_q == LOCKED) begin
            gnt_id = owner_q;
            for (int i = 0; i < N_REQ; i++) begin
                gnt_vec[i] = (owner_q == IDW'(i));
            end
            accept = req_valid_i[owner_q];
        end else begin
            gnt_vec = pick_gnt;
            accept  = pick_any;
        end
        if (rst_i) begin
            accept = 1'b0;
        end
    end

    assign req_ready_o = accept ? gnt_vec : '0;
    assign acc_we      = req_we_i[gnt_id];
    assign acc_last    = req_last_i[gnt_id];
    assign acc_addr    = req_addr_i[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign acc_wdata   = req_wdata_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
    assign acc_strb    = req_strb_i[gnt_id*STRB_N +: STRB_N];

    // RAM request side: address/data hold their last value between beats so
    // the RAM inputs do not toggle while idle.
    always_comb begin
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        ram_byte_en_o = '0;
        if (accept) begin
            addr_d  = acc_addr;
            wdata_d = acc_wdata;
            if (acc_we) begin
                ram_byte_en_o = acc_strb;
            end
        end
        pipe_d[0] = '{valid: accept, id: ID_W'(gnt_id), we: acc_we};
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign ram_addr_o  = addr_d;
    assign ram_wdata_o = wdata_d;

    // Lock FSM. The round-robin pointer only advances when the port returns
    // to IDLE, so a burst counts as a single turn.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        ovf_d      = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (acc_last) begin
                        rr_ptr_d = inc_wrap(gnt_id);
                    end else begin
                        state_d    = LOCKED;
                        owner_d    = gnt_id;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (acc_last || (beat_cnt_q == CNT_MAX)) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        rr_ptr_d   = inc_wrap(owner_q);
                        ovf_d      = !acc_last;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            ovf_q      <= ovf_d;
            pipe_q     <= pipe_d;
        end
    end

    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Response side: the last pipe stage lines up with RAM read data.
    // Gating with rst_i keeps a beat accepted just before reset from
    // surfacing in the reset cycle.
    assign rsp_last = pipe_q[RD_LAT-1];

    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_o[i] = rsp_last.valid && (rsp_last.id == ID_W'(i)) && !rst_i;
        end
        rsp_we_o = rsp_last.valid && rsp_last.we && !rst_i;
    end

    assign rsp_rdata_o = ram_rdata_i;
    assign burst_ovf_o = ovf_q;

endmodule : ram_port_arbiter

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_addr;
    logic [127:0] req_wdata;
    logic [15:0] req_strb;
    logic [3:0]  req_we;
    logic [3:0]  req_last;
    logic [3:0]  rsp_valid;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] ram_wr_word;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .N_REQ      (4),
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .BYTE_WIDTH (8),
        .RD_LAT     (1),
        .MAX_BURST  (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_strb_i    (req_strb),
        .req_we_i      (req_we),
        .req_last_i    (req_last),
        .rsp_valid_o   (rsp_valid),
        .rsp_we_o      (rsp_we),
        .rsp_rdata_o   (rsp_rdata),
        .ram_addr_o    (ram_addr),
        .ram_wdata_o   (ram_wdata),
        .ram_byte_en_o (ram_be),
        .ram_rdata_i   (ram_rdata),
        .burst_ovf_o   (ovf)
    );

    // Write-first RAM, one cycle read latency; contents seeded on reset.
    always_comb begin
        ram_wr_word = mem[ram_addr];
        for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) ram_wr_word[b*8 +: 8] = ram_wdata[b*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 32'h1000_0000 + i;
        end else begin
            if (|ram_be) mem[ram_addr] <= ram_wr_word;
            ram_rdata <= ram_wr_word;
        end
    end

    task automatic set_req(input int i, input logic v, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic we, input logic last);
        req_valid[i]         = v;
        req_addr[i*16 +: 16] = a;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4]   = s;
        req_we[i]            = we;
        req_last[i]          = last;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_last  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_addr = '0; req_wdata = '0; req_strb = '0;
        clear_reqs();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'(i), 32'h0, 4'hF, 1'b1, 1'b1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        total++; if (rsp_we !== 1'b0) begin bad++; $display("FAIL reset_rsp_we got=%b exp=0", rsp_we); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        total++; if (ram_be !== 4'b0000) begin bad++; $display("FAIL reset_byte_en got=%b exp=0000", ram_be); end
        next_cycle();
        rst = 1'b0;
        clear_reqs();
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready got=%b exp=0000", req_ready); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_rdy;
        logic [3:0] exp_rsp;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k == 0) begin
                for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'(i), 32'h0, 4'hF, 1'b0, 1'b1);
            end else begin
                req_valid[k-1] = 1'b0;
            end
            @(negedge clk);
            exp_rdy = 4'b0001 << k;
            exp_rsp = (k == 0) ? 4'b0000 : (4'b0001 << (k - 1));
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL simul_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
            total++; if (rsp_valid !== exp_rsp) begin bad++; $display("FAIL simul_rsp k=%0d got=%b exp=%b", k, rsp_valid, exp_rsp); end
            if (k > 0) begin
                total++; if (rsp_rdata !== 32'h1000_0000 + 32'(k - 1)) begin bad++; $display("FAIL simul_rdata k=%0d got=%h exp=%h", k, rsp_rdata, 32'h1000_0000 + 32'(k - 1)); end
            end
        end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        total++; if (rsp_valid !== 4'b1000) begin bad++; $display("FAIL simul_rsp_last got=%b exp=1000", rsp_valid); end
        total++; if (rsp_rdata !== 32'h1000_0003) begin bad++; $display("FAIL simul_rdata_last got=%h exp=10000003", rsp_rdata); end
    endtask

    task automatic test_write_read();
        next_cycle();
        set_req(1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wr_ready got=%b exp=0010", req_ready); end
        total++; if (ram_be !== 4'hF) begin bad++; $display("FAIL wr_byte_en got=%b exp=1111", ram_be); end
        total++; if (ram_addr !== 16'h0010) begin bad++; $display("FAIL wr_addr got=%h exp=0010", ram_addr); end
        total++; if (ram_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_wdata got=%h exp=deadbeef", ram_wdata); end
        next_cycle();
        set_req(1, 1'b1, 16'h0010, 32'h0, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rd_ready got=%b exp=0010", req_ready); end
        total++; if (ram_be !== 4'h0) begin bad++; $display("FAIL rd_byte_en got=%b exp=0000", ram_be); end
        total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL wr_ack_valid got=%b exp=0010", rsp_valid); end
        total++; if (rsp_we !== 1'b1) begin bad++; $display("FAIL wr_ack_we got=%b exp=1", rsp_we); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL rd_rsp_valid got=%b exp=0010", rsp_valid); end
        total++; if (rsp_we !== 1'b0) begin bad++; $display("FAIL rd_rsp_we got=%b exp=0", rsp_we); end
        total++; if (rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL raw_rdata got=%h exp=deadbeef", rsp_rdata); end
        total++; if (ram_addr !== 16'h0010) begin bad++; $display("FAIL idle_addr_hold got=%h exp=0010", ram_addr); end
    endtask

    task automatic test_burst_lock();
        logic [3:0] exp_rsp;
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            if (b == 0) begin
                set_req(0, 1'b1, 16'h0040, 32'h0, 4'hF, 1'b0, 1'b1);
                set_req(3, 1'b1, 16'h0043, 32'h0, 4'hF, 1'b0, 1'b1);
            end
            set_req(2, 1'b1, 16'h0020 + 16'(b), 32'h0, 4'hF, 1'b0, (b == 3));
            @(negedge clk);
            exp_rsp = (b == 0) ? 4'b0000 : 4'b0100;
            total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL lock_ready beat=%0d got=%b exp=0100", b, req_ready); end
            total++; if (rsp_valid !== exp_rsp) begin bad++; $display("FAIL lock_rsp beat=%0d got=%b exp=%b", b, rsp_valid, exp_rsp); end
        end
        next_cycle();
        req_valid[2] = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL after_lock_ready got=%b exp=1000", req_ready); end
        total++; if (rsp_rdata !== 32'h1000_0023) begin bad++; $display("FAIL lock_rdata got=%h exp=10000023", rsp_rdata); end
        next_cycle();
        req_valid[3] = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL after_lock_ready2 got=%b exp=0001", req_ready); end
        total++; if (rsp_valid !== 4'b1000) begin bad++; $display("FAIL after_lock_rsp got=%b exp=1000", rsp_valid); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL after_lock_rsp2 got=%b exp=0001", rsp_valid); end
    endtask

    task automatic test_max_burst();
        logic [3:0] exp_rdy;
        for (int c = 0; c <= 20; c++) begin
            next_cycle();
            set_req(0, 1'b1, 16'h0050 + 16'(c), 32'h0, 4'hF, 1'b0, 1'b0);
            if (c == 1) set_req(1, 1'b1, 16'h0060, 32'h0, 4'hF, 1'b0, 1'b1);
            if (c == 17) req_valid[1] = 1'b0;
            @(negedge clk);
            exp_rdy = (c == 16) ? 4'b0010 : 4'b0001;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL maxb_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            total++; if (ovf !== (c == 16)) begin bad++; $display("FAIL maxb_ovf c=%0d got=%b exp=%b", c, ovf, (c == 16)); end
        end
        // Owner 0 is locked again; it pauses and requester 2 must wait.
        next_cycle();
        req_valid[0] = 1'b0;
        set_req(2, 1'b1, 16'h0090, 32'h0, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL owner_pause_ready got=%b exp=0000", req_ready); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL owner_pause_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_partial_write();
        next_cycle();
        clear_reqs();
        set_req(0, 1'b1, 16'h0030, 32'hAAAA_AAAA, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL pw_full_ready got=%b exp=0001", req_ready); end
        next_cycle();
        set_req(0, 1'b1, 16'h0030, 32'h1122_3344, 4'b0101, 1'b1, 1'b1);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL pw_part_ready got=%b exp=0001", req_ready); end
        total++; if (ram_be !== 4'b0101) begin bad++; $display("FAIL pw_byte_en got=%b exp=0101", ram_be); end
        total++; if (rsp_we !== 1'b1) begin bad++; $display("FAIL pw_ack_we got=%b exp=1", rsp_we); end
        next_cycle();
        set_req(0, 1'b1, 16'h0030, 32'h0, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (ram_be !== 4'b0000) begin bad++; $display("FAIL pw_rd_byte_en got=%b exp=0000", ram_be); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL pw_rsp_valid got=%b exp=0001", rsp_valid); end
        total++; if (rsp_rdata !== 32'hAA22_AA44) begin bad++; $display("FAIL pw_rdata got=%h exp=aa22aa44", rsp_rdata); end
    endtask

    task automatic test_reset_mid_burst();
        next_cycle();
        set_req(0, 1'b1, 16'h0070, 32'h0, 4'hF, 1'b0, 1'b1);
        set_req(2, 1'b1, 16'h0080, 32'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rmb_beat1_ready got=%b exp=0100", req_ready); end
        next_cycle();
        rst = 1'b1;
        set_req(2, 1'b1, 16'h0081, 32'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rmb_rst_ready got=%b exp=0000", req_ready); end
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rmb_rst_rsp got=%b exp=0000", rsp_valid); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmb_after_ready got=%b exp=0001", req_ready); end
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rmb_after_rsp got=%b exp=0000", rsp_valid); end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL rmb_req0_rsp got=%b exp=0001", rsp_valid); end
        total++; if (rsp_rdata !== 32'h1000_0070) begin bad++; $display("FAIL rmb_req0_rdata got=%h exp=10000070", rsp_rdata); end
        next_cycle();
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rmb_quiet_rsp got=%b exp=0000", rsp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_simultaneous();
        test_write_read();
        test_burst_lock();
        test_max_burst();
        test_partial_write();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ram_port_arbiter
